// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, constants and priority helper for the RGB LED arbiter
package led_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [2:0] LED_OFF  = 3'b111;
  localparam logic [2:0] ROT_INIT = 3'b110;

  // Isolates the lowest set bit; bit 0 is the highest priority requester.
  function automatic logic [2:0] prio_pick(input logic [2:0] req);
    prio_pick = req & (~req + 3'd1);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running divider producing a one-cycle tick every TICK_DIV cycles
module led_tick_gen #(
  parameter int TICK_DIV = 12_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/rgb_led_arbiter.sv
// rtl/rgb_led_arbiter.sv - fixed-priority req/gnt arbiter sharing one active-low RGB LED
module rgb_led_arbiter
  import led_pkg::*;
#(
  parameter int TICK_DIV = 12_000_000,
  parameter int MIN_HOLD = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] req,
  input  logic [2:0] color0,
  input  logic [2:0] color1,
  input  logic [2:0] color2,
  input  logic [2:0] blink,
  output logic [2:0] gnt,
  output logic [2:0] led,
  output logic       tick
);

  localparam int            HW       = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  state_t        state, state_n;
  logic [2:0]    gnt_n, led_n, rot, rot_n, pick;
  logic [2:0]    sel_color;
  logic          sel_blink;
  logic          phase_on, phase_on_n;
  logic [HW-1:0] hold, hold_n;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      led      <= ROT_INIT;
      rot      <= ROT_INIT;
      phase_on <= 1'b1;
      hold     <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      led      <= led_n;
      rot      <= rot_n;
      phase_on <= phase_on_n;
      hold     <= hold_n;
    end
  end

  // Any (re)grant restarts the blink phase and hold count and swallows a coincident tick.
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    rot_n      = rot;
    phase_on_n = phase_on;
    hold_n     = hold;
    pick       = prio_pick(req);
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_n      = pick;
          state_n    = GRANT;
          phase_on_n = 1'b1;
          hold_n     = '0;
        end else if (tick) begin
          rot_n = {rot[1:0], rot[2]};
        end
      end
      GRANT: begin
        if (!(|(req & gnt))) begin
          phase_on_n = 1'b1;
          hold_n     = '0;
          gnt_n      = pick;
          if (!(|req)) begin
            state_n = IDLE;
          end
        end else if (hold == HOLD_MAX && pick != gnt) begin
          gnt_n      = pick;
          phase_on_n = 1'b1;
          hold_n     = '0;
        end else if (tick) begin
          phase_on_n = ~phase_on;
          if (hold != HOLD_MAX) begin
            hold_n = hold + HW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sel_color = 3'b000;
    sel_blink = |(blink & gnt_n);
    if (gnt_n[0]) begin
      sel_color = color0;
    end else if (gnt_n[1]) begin
      sel_color = color1;
    end else if (gnt_n[2]) begin
      sel_color = color2;
    end
    if (state_n == IDLE) begin
      led_n = rot_n;
    end else if (phase_on_n || !sel_blink) begin
      led_n = ~sel_color;
    end else begin
      led_n = LED_OFF;
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb/tb_rgb_led_arbiter.sv - self-checking bench for rgb_led_arbiter with a behavioural model
module tb_rgb_led_arbiter;

  localparam int TICK_DIV = 4;
  localparam int MIN_HOLD = 2;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] req    = 3'b000;
  logic [2:0] color0 = 3'b000;
  logic [2:0] color1 = 3'b000;
  logic [2:0] color2 = 3'b000;
  logic [2:0] blink  = 3'b000;
  logic [2:0] gnt, led;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  rgb_led_arbiter #(.TICK_DIV(TICK_DIV), .MIN_HOLD(MIN_HOLD)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .color0    (color0),
    .color1    (color1),
    .color2    (color2),
    .blink     (blink),
    .gnt       (gnt),
    .led       (led),
    .tick      (tick)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: integer owner (-1 = nobody), rotation index into a pattern table.
  int         m_cnt   = 0;
  int         m_rot   = 0;
  int         m_owner = -1;
  int         m_hold  = 0;
  int         m_top   = -1;
  bit         m_on    = 1'b1;
  bit         m_tk    = 1'b0;
  logic [2:0] m_led   = 3'b110;

  function automatic logic [2:0] rot_pat(input int i);
    case (i)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  function automatic int lowest(input logic [2:0] r);
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] col_of(input int i);
    case (i)
      0:       return color0;
      1:       return color1;
      default: return color2;
    endcase
  endfunction

  function automatic logic [2:0] m_gnt();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  function automatic logic m_tick();
    return (m_cnt == TICK_DIV - 1);
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_cnt = 0; m_rot = 0; m_owner = -1; m_hold = 0; m_on = 1'b1; m_led = 3'b110;
    end else begin
      m_tk  = (m_cnt == TICK_DIV - 1);
      m_top = lowest(req);
      if (m_owner < 0) begin
        if (m_top >= 0) begin
          m_owner = m_top; m_on = 1'b1; m_hold = 0;
        end else if (m_tk) begin
          m_rot = (m_rot + 1) % 3;
        end
      end else if (!req[m_owner]) begin
        m_owner = m_top; m_on = 1'b1; m_hold = 0;
      end else if (m_hold == MIN_HOLD && m_top < m_owner) begin
        m_owner = m_top; m_on = 1'b1; m_hold = 0;
      end else if (m_tk) begin
        m_on = !m_on;
        if (m_hold < MIN_HOLD) m_hold++;
      end
      if (m_owner < 0)                      m_led = rot_pat(m_rot);
      else if (m_on || !blink[m_owner])     m_led = ~col_of(m_owner);
      else                                  m_led = 3'b111;
      m_cnt = (m_cnt + 1) % TICK_DIV;
    end
  end

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    req = 3'b000;
    step();
    step();
    n_checks++;
    if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt actual=%b expected=000", gnt); end
    n_checks++;
    if (led !== 3'b110) begin n_fail++; $display("FAIL reset_led actual=%b expected=110", led); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick actual=%b expected=0", tick); end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_idle_rotation();
    logic [2:0] seq [3];
    seq = '{3'b101, 3'b011, 3'b110};
    for (int c = 1; c <= 12; c++) begin
      step();
      n_checks++;
      if (gnt !== 3'b000) begin n_fail++; $display("FAIL idle_gnt cycle=%0d actual=%b expected=000", c, gnt); end
      n_checks++;
      if (led !== m_led) begin n_fail++; $display("FAIL idle_led_model cycle=%0d actual=%b expected=%b", c, led, m_led); end
      n_checks++;
      if (tick !== m_tick()) begin n_fail++; $display("FAIL idle_tick cycle=%0d actual=%b expected=%b", c, tick, m_tick()); end
      if (c % 4 == 0) begin
        n_checks++;
        if (led !== seq[c/4-1]) begin n_fail++; $display("FAIL idle_rot cycle=%0d actual=%b expected=%b", c, led, seq[c/4-1]); end
      end
    end
  endtask

  task automatic test_grant_steady();
    req = 3'b100; color2 = 3'b100; blink = 3'b000;
    step();
    n_checks++;
    if (gnt !== 3'b100 || led !== 3'b011) begin
      n_fail++; $display("FAIL grant_latency actual=gnt %b led %b expected=gnt 100 led 011", gnt, led);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (gnt !== 3'b100 || led !== 3'b011) begin
        n_fail++; $display("FAIL grant_steady cycle=%0d actual=gnt %b led %b expected=gnt 100 led 011", c, gnt, led);
      end
    end
  endtask

  task automatic test_preempt();
    int guard;
    logic [2:0] exp_g;
    req = 3'b000;
    step();
    req = 3'b100;
    step();
    guard = 0;
    while (tick !== 1'b1 && guard < 20) begin step(); guard++; end
    n_checks++;
    if (guard >= 20) begin n_fail++; $display("FAIL preempt_tick_wait actual=timeout expected=tick"); end
    step();
    req = 3'b101;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_g = (k < 5) ? 3'b100 : 3'b001;
      n_checks++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL preempt_gnt edge=%0d actual=%b expected=%b", k, gnt, exp_g); end
      n_checks++;
      if (gnt !== m_gnt()) begin n_fail++; $display("FAIL preempt_model edge=%0d actual=%b expected=%b", k, gnt, m_gnt()); end
    end
  endtask

  task automatic test_blink();
    int guard;
    logic [2:0] seq [3];
    seq = '{3'b111, 3'b101, 3'b111};
    req = 3'b000;
    step();
    req = 3'b001; color0 = 3'b010; blink = 3'b001;
    step();
    n_checks++;
    if (gnt !== 3'b001 || led !== 3'b101) begin
      n_fail++; $display("FAIL blink_start actual=gnt %b led %b expected=gnt 001 led 101", gnt, led);
    end
    for (int p = 0; p < 3; p++) begin
      guard = 0;
      while (tick !== 1'b1 && guard < 20) begin step(); guard++; end
      step();
      n_checks++;
      if (guard >= 20 || led !== seq[p]) begin
        n_fail++; $display("FAIL blink_phase step=%0d actual=%b expected=%b", p, led, seq[p]);
      end
    end
  endtask

  task automatic test_release();
    int guard;
    req = 3'b000; blink = 3'b000;
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) step();
    n_checks++;
    if (led !== 3'b101) begin n_fail++; $display("FAIL release_rot_setup actual=%b expected=101", led); end
    req = 3'b010; color1 = 3'b001;
    step();
    n_checks++;
    if (gnt !== 3'b010 || led !== 3'b110) begin
      n_fail++; $display("FAIL release_grant actual=gnt %b led %b expected=gnt 010 led 110", gnt, led);
    end
    for (int c = 0; c < 6; c++) step();
    req = 3'b000;
    step();
    n_checks++;
    if (gnt !== 3'b000 || led !== 3'b101) begin
      n_fail++; $display("FAIL release_idle actual=gnt %b led %b expected=gnt 000 led 101", gnt, led);
    end
    guard = 0;
    while (tick !== 1'b1 && guard < 20) begin step(); guard++; end
    step();
    n_checks++;
    if (guard >= 20 || led !== 3'b011) begin n_fail++; $display("FAIL release_resume actual=%b expected=011", led); end
  endtask

  task automatic test_async_reset();
    req = 3'b001; color0 = 3'b111; blink = 3'b000;
    step();
    n_checks++;
    if (gnt !== 3'b001 || led !== 3'b000) begin
      n_fail++; $display("FAIL areset_setup actual=gnt %b led %b expected=gnt 001 led 000", gnt, led);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 3'b000 || led !== 3'b110) begin
      n_fail++; $display("FAIL areset_immediate actual=gnt %b led %b expected=gnt 000 led 110", gnt, led);
    end
    req = 3'b000;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) color0 = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) color1 = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) color2 = 3'($urandom_range(7));
      if ($urandom_range(15) == 0) blink = 3'($urandom_range(7));
      step();
      n_checks++;
      if (gnt !== m_gnt()) begin n_fail++; $display("FAIL rand_gnt cycle=%0d actual=%b expected=%b", c, gnt, m_gnt()); end
      n_checks++;
      if (led !== m_led) begin n_fail++; $display("FAIL rand_led cycle=%0d actual=%b expected=%b", c, led, m_led); end
      n_checks++;
      if (tick !== m_tick()) begin n_fail++; $display("FAIL rand_tick cycle=%0d actual=%b expected=%b", c, tick, m_tick()); end
      n_checks++;
      if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rand_onehot cycle=%0d actual=%b expected=at most one bit", c, gnt); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_rotation();
    test_grant_steady();
    test_preempt();
    test_blink();
    test_release();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
